fp_mult_pipe: RTL and testbench
===============================

# fp_mult_pipe

Parametrised, pipelined IEEE-style floating-point multiplier; successor to the single-cycle combinational BF16 multiplier. Supports configurable exponent/mantissa widths (BF16 by default, FP16/FP32 by parameter), round-to-nearest-even, exception flags, and a valid/ready stream interface with a sideband tag. Sits in the MAC datapath of the matmul array, between the operand fetch stage and the accumulator adder.

## Interface
- EXP_W, 8, exponent field width (≥4)
- MAN_W, 7, stored fraction width (≥2); word width W = 1+EXP_W+MAN_W
- TAG_W, 4, sideband tag width, passed through unchanged
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands this cycle
- a, b  in  W each  operands {sign, exp, frac}
- in_tag  in  TAG_W  sideband
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- o  out  W  product
- out_tag  out  TAG_W  tag of this result
- flags  out  4  {invalid, overflow, underflow, inexact}

## Operation
- BIAS = 2^(EXP_W-1)-1; EMAX = 2^EXP_W-1 (all-ones).
- Three stages, one register set each (valid, data, tag):
- S1 unpack/classify: NaN (exp=EMAX, frac≠0), Inf (exp=EMAX, frac=0), zero (exp=0, any frac — subnormal inputs flush to zero), normal. Sign = a.sign ^ b.sign. Exponent sum es = ea+eb-BIAS, signed, EXP_W+2 bits.
- S2: unsigned product P = {1,fa}×{1,fb}, 2·MAN_W+2 bits.
- S3 normalise/round/pack: if P MSB set, es+1 and use upper bits; else shift by one less. Keep MAN_W fraction bits, guard = next bit, sticky = OR of remaining. RNE: increment if guard & (sticky | lsb). Increment carry-out → fraction 0, es+1.
- Result priority: any NaN input, or Inf×zero → canonical qNaN (sign 0, exp EMAX, frac MSB 1, rest 0), invalid=1. Else Inf operand → Inf with product sign. Else zero operand → signed zero, no flags. Else es ≥ EMAX → signed Inf, overflow=1, inexact=1. Else es ≤ 0 → signed zero, underflow=1, inexact=1. Else normal result, inexact = guard|sticky.
- flags accompany o and out_tag; all three change only with out_valid handshake.

## Timing
- Reset: all stage valids 0, out_valid=0, o=0, out_tag=0, flags=0; in_ready=1 once rst_n deasserts. Reset asserted mid-operation discards all in-flight results immediately; no partial output.
- Latency 3 cycles: operand accepted at edge N (in_valid & in_ready) is presented at out_valid after edge N+3.
- Throughput 1 per cycle when out_ready=1.
- Global stall: en = !out_valid | out_ready; in_ready = en. When en=0 every stage holds; bubbles are not compressed.
- out_valid & !out_ready: o, out_tag, flags held stable until accepted.
- in_valid with in_ready=0: operand not captured; source must hold.
- Simultaneous accept at output and input: both occur same edge, pipeline advances.
- Results emerge strictly in acceptance order.

## Test plan
- BF16 basics: 0x3FC0×0x3FC0 → 0x4010, flags 0; 0xBF80×0x4000 → 0xC000, flags 0; output 3 cycles after accept.
- Rounding: 0x3F81×0x3F81 → 0x3F82, inexact=1 (round down); 0x3F81×0x3FC0 → 0x3FC2, inexact=1 (tie, rounds to even).
- Specials: 0x7F80×0x0000 → 0x7FC0, invalid=1; 0x7FC1×0x3F80 → 0x7FC0, invalid=1; 0xFF80×0x4000 → 0xFF80, flags 0; 0x8000×0x4000 → 0x8000.
- Range: 0x7F00×0x4000 → 0x7F80, overflow=1, inexact=1; 0x0080×0x3F00 → 0x0000, underflow=1, inexact=1; subnormal 0x0001×0x3F80 → 0x0000, no flags.
- Backpressure: stream 16 operands with tags 0..15 at in_valid=1, hold out_ready=0 for 5 cycles mid-stream → in_ready drops while out_valid stalled, o held stable, all 16 results delivered in tag order, none lost or duplicated.
- Reset mid-stream: assert rst_n=0 with 3 results in flight → out_valid=0 asynchronously; after release, first new operand appears 3 cycles after accept with no stale outputs. Repeat first scenario with EXP_W=5, MAN_W=10: 0x3E00×0x3E00 → 0x4080.

Source files
------------

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: pipelined floating-point multiplier with a valid/ready stream
// interface and a sideband tag.
//   Operand capture -> S1 unpack/classify -> S2 mantissa product ->
//   S3 normalise/round/pack (output register).
//   An operand accepted at edge N is presented on out_valid after edge N+3.
// Subnormal inputs are flushed to zero. Results below the normal range
// become signed zero. Rounding is round-to-nearest-even.
// All stages advance together on en_s. Bubbles are kept, not squeezed out.
module fp_mult_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     o,
    output logic [TAG_W-1:0]         out_tag,
    output logic [3:0]               flags
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int ES_W = EXP_W + 2;
    localparam int PW   = 2 * MAN_W + 2;

    localparam logic [EXP_W-1:0]        EMAX     = {EXP_W{1'b1}};
    localparam logic signed [ES_W-1:0]  BIAS     = ES_W'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [ES_W-1:0]  EMAX_ES  = $signed({2'b00, EMAX});
    localparam logic signed [ES_W-1:0]  ES_ONE   = ES_W'(1);
    localparam logic signed [ES_W-1:0]  ES_ZERO  = ES_W'(0);

    // ------------------------------------------------------------------
    // Global advance: the whole pipe moves unless the output is stalled
    // ------------------------------------------------------------------
    logic en_s;
    logic out_valid_q;

    assign en_s     = !out_valid_q || out_ready;
    assign in_ready = en_s;

    // ------------------------------------------------------------------
    // Operand capture register
    // ------------------------------------------------------------------
    logic             v0_q,   v0_d;
    logic [W-1:0]     a0_q,   a0_d;
    logic [W-1:0]     b0_q,   b0_d;
    logic [TAG_W-1:0] tag0_q, tag0_d;

    // Capture operands when the pipe advances
    always_comb begin
        v0_d   = v0_q;
        a0_d   = a0_q;
        b0_d   = b0_q;
        tag0_d = tag0_q;
        if (en_s) begin
            v0_d   = in_valid;
            a0_d   = a;
            b0_d   = b;
            tag0_d = in_tag;
        end else begin
            v0_d   = v0_q;
        end
    end

    // ------------------------------------------------------------------
    // S1: unpack and classify
    // ------------------------------------------------------------------
    logic [EXP_W-1:0]        ea_s, eb_s;
    logic [MAN_W-1:0]        fa_s, fb_s;
    logic                    a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
    logic signed [ES_W-1:0]  es_s;

    logic                    v1_q,    v1_d;
    logic [TAG_W-1:0]        tag1_q,  tag1_d;
    logic                    sign1_q, sign1_d;
    logic signed [ES_W-1:0]  es1_q,   es1_d;
    logic                    nan1_q,  nan1_d;
    logic                    inf1_q,  inf1_d;
    logic                    zero1_q, zero1_d;
    logic [MAN_W:0]          ma1_q,   ma1_d;
    logic [MAN_W:0]          mb1_q,   mb1_d;

    assign ea_s = a0_q[W-2:MAN_W];
    assign eb_s = b0_q[W-2:MAN_W];
    assign fa_s = a0_q[MAN_W-1:0];
    assign fb_s = b0_q[MAN_W-1:0];

    // Classify both operands and form the biased exponent sum
    always_comb begin
        a_nan_s  = (ea_s == EMAX) && (fa_s != {MAN_W{1'b0}});
        b_nan_s  = (eb_s == EMAX) && (fb_s != {MAN_W{1'b0}});
        a_inf_s  = (ea_s == EMAX) && (fa_s == {MAN_W{1'b0}});
        b_inf_s  = (eb_s == EMAX) && (fb_s == {MAN_W{1'b0}});
        a_zero_s = (ea_s == {EXP_W{1'b0}});
        b_zero_s = (eb_s == {EXP_W{1'b0}});
        es_s     = $signed({2'b00, ea_s}) + $signed({2'b00, eb_s}) - BIAS;
    end

    // S1 register update; Inf x zero is folded into the NaN class here
    always_comb begin
        v1_d    = v1_q;
        tag1_d  = tag1_q;
        sign1_d = sign1_q;
        es1_d   = es1_q;
        nan1_d  = nan1_q;
        inf1_d  = inf1_q;
        zero1_d = zero1_q;
        ma1_d   = ma1_q;
        mb1_d   = mb1_q;
        if (en_s) begin
            v1_d    = v0_q;
            tag1_d  = tag0_q;
            sign1_d = a0_q[W-1] ^ b0_q[W-1];
            es1_d   = es_s;
            nan1_d  = a_nan_s || b_nan_s || (a_inf_s && b_zero_s) || (a_zero_s && b_inf_s);
            inf1_d  = a_inf_s || b_inf_s;
            zero1_d = a_zero_s || b_zero_s;
            ma1_d   = {1'b1, fa_s};
            mb1_d   = {1'b1, fb_s};
        end else begin
            v1_d    = v1_q;
        end
    end

    // ------------------------------------------------------------------
    // S2: mantissa product
    // ------------------------------------------------------------------
    logic                    v2_q,    v2_d;
    logic [TAG_W-1:0]        tag2_q,  tag2_d;
    logic                    sign2_q, sign2_d;
    logic signed [ES_W-1:0]  es2_q,   es2_d;
    logic                    nan2_q,  nan2_d;
    logic                    inf2_q,  inf2_d;
    logic                    zero2_q, zero2_d;
    logic [PW-1:0]           p2_q,    p2_d;

    // Multiply the significands with hidden ones restored
    always_comb begin
        v2_d    = v2_q;
        tag2_d  = tag2_q;
        sign2_d = sign2_q;
        es2_d   = es2_q;
        nan2_d  = nan2_q;
        inf2_d  = inf2_q;
        zero2_d = zero2_q;
        p2_d    = p2_q;
        if (en_s) begin
            v2_d    = v1_q;
            tag2_d  = tag1_q;
            sign2_d = sign1_q;
            es2_d   = es1_q;
            nan2_d  = nan1_q;
            inf2_d  = inf1_q;
            zero2_d = zero1_q;
            p2_d    = PW'(ma1_q) * PW'(mb1_q);
        end else begin
            v2_d    = v2_q;
        end
    end

    // ------------------------------------------------------------------
    // S3: normalise, round, pack
    // ------------------------------------------------------------------
    logic [PW-2:0]           norm_s;
    logic [MAN_W-1:0]        frac_s, frac_r_s;
    logic                    guard_s, sticky_s, inc_s, carry_s;
    logic signed [ES_W-1:0]  es_n_s, es_f_s;
    logic [W-1:0]            res_o_s;
    logic [3:0]              res_flags_s;

    // Align the product so its leading one is dropped, then round to nearest even
    always_comb begin
        if (p2_q[PW-1]) begin
            norm_s = p2_q[PW-2:0];
            es_n_s = es2_q + ES_ONE;
        end else begin
            norm_s = {p2_q[PW-3:0], 1'b0};
            es_n_s = es2_q;
        end
        frac_s              = norm_s[PW-2 -: MAN_W];
        guard_s             = norm_s[MAN_W];
        sticky_s            = |norm_s[MAN_W-1:0];
        inc_s               = guard_s && (sticky_s || frac_s[0]);
        {carry_s, frac_r_s} = {1'b0, frac_s} + {{MAN_W{1'b0}}, inc_s};
        if (carry_s) begin
            es_f_s = es_n_s + ES_ONE;
        end else begin
            es_f_s = es_n_s;
        end
    end

    // Pick the final encoding by exception priority
    always_comb begin
        res_o_s     = {W{1'b0}};
        res_flags_s = 4'b0000;
        if (nan2_q) begin
            res_o_s     = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
            res_flags_s = 4'b1000;
        end else if (inf2_q) begin
            res_o_s     = {sign2_q, EMAX, {MAN_W{1'b0}}};
            res_flags_s = 4'b0000;
        end else if (zero2_q) begin
            res_o_s     = {sign2_q, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
            res_flags_s = 4'b0000;
        end else if (es_f_s >= EMAX_ES) begin
            res_o_s     = {sign2_q, EMAX, {MAN_W{1'b0}}};
            res_flags_s = 4'b0101;
        end else if (es_f_s <= ES_ZERO) begin
            res_o_s     = {sign2_q, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
            res_flags_s = 4'b0011;
        end else begin
            res_o_s     = {sign2_q, es_f_s[EXP_W-1:0], frac_r_s};
            res_flags_s = {3'b000, guard_s || sticky_s};
        end
    end

    logic             out_valid_d;
    logic [W-1:0]     o_q,       o_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [3:0]       flags_q,   flags_d;

    // Output register: data only changes when a new valid result is loaded
    always_comb begin
        out_valid_d = out_valid_q;
        o_d         = o_q;
        out_tag_d   = out_tag_q;
        flags_d     = flags_q;
        if (en_s) begin
            out_valid_d = v2_q;
            if (v2_q) begin
                o_d       = res_o_s;
                out_tag_d = tag2_q;
                flags_d   = res_flags_s;
            end else begin
                o_d       = o_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // All pipeline state; reset drops every in-flight result at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_q        <= 1'b0;
            a0_q        <= {W{1'b0}};
            b0_q        <= {W{1'b0}};
            tag0_q      <= {TAG_W{1'b0}};
            v1_q        <= 1'b0;
            tag1_q      <= {TAG_W{1'b0}};
            sign1_q     <= 1'b0;
            es1_q       <= ES_ZERO;
            nan1_q      <= 1'b0;
            inf1_q      <= 1'b0;
            zero1_q     <= 1'b0;
            ma1_q       <= {(MAN_W+1){1'b0}};
            mb1_q       <= {(MAN_W+1){1'b0}};
            v2_q        <= 1'b0;
            tag2_q      <= {TAG_W{1'b0}};
            sign2_q     <= 1'b0;
            es2_q       <= ES_ZERO;
            nan2_q      <= 1'b0;
            inf2_q      <= 1'b0;
            zero2_q     <= 1'b0;
            p2_q        <= {PW{1'b0}};
            out_valid_q <= 1'b0;
            o_q         <= {W{1'b0}};
            out_tag_q   <= {TAG_W{1'b0}};
            flags_q     <= 4'b0000;
        end else begin
            v0_q        <= v0_d;
            a0_q        <= a0_d;
            b0_q        <= b0_d;
            tag0_q      <= tag0_d;
            v1_q        <= v1_d;
            tag1_q      <= tag1_d;
            sign1_q     <= sign1_d;
            es1_q       <= es1_d;
            nan1_q      <= nan1_d;
            inf1_q      <= inf1_d;
            zero1_q     <= zero1_d;
            ma1_q       <= ma1_d;
            mb1_q       <= mb1_d;
            v2_q        <= v2_d;
            tag2_q      <= tag2_d;
            sign2_q     <= sign2_d;
            es2_q       <= es2_d;
            nan2_q      <= nan2_d;
            inf2_q      <= inf2_d;
            zero2_q     <= zero2_d;
            p2_q        <= p2_d;
            out_valid_q <= out_valid_d;
            o_q         <= o_d;
            out_tag_q   <= out_tag_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign o         = o_q;
    assign out_tag   = out_tag_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Self-checking bench for fp_mult_pipe: BF16 instance (directed, backpressure,
// reset, randomized stream against a value-level model) plus an FP16 instance.
module tb_fp_mult_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    // BF16 instance
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, o;
    logic [3:0]  in_tag, out_tag, flags;

    // FP16 instance
    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0] h_a, h_b, h_o;
    logic [3:0]  h_in_tag, h_out_tag, h_flags;

    fp_mult_pipe #(.EXP_W(8), .MAN_W(7), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .o(o), .out_tag(out_tag), .flags(flags)
    );

    fp_mult_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut_h (
        .clk(clk), .rst_n(rst_n),
        .in_valid(h_in_valid), .in_ready(h_in_ready), .a(h_a), .b(h_b), .in_tag(h_in_tag),
        .out_valid(h_out_valid), .out_ready(h_out_ready), .o(h_o), .out_tag(h_out_tag), .flags(h_flags)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    // Value-level reference: exact integer product, rounded by remainder vs half-ulp
    function automatic void ref_mul(input int ew, input int mw, input longint av, input longint bv,
                                    output longint ov, output longint fv);
        longint bias, emax, w, sa, sb, ea, eb, fa, fb, s, ma, mb, val, e, sh, q, rem, half, qnan, mmask;
        bit an, bn, ai, bi, az, bz;
        bias  = (longint'(1) << (ew - 1)) - 1;
        emax  = (longint'(1) << ew) - 1;
        mmask = (longint'(1) << mw) - 1;
        w     = 1 + ew + mw;
        sa = (av >> (w - 1)) & 1;  sb = (bv >> (w - 1)) & 1;
        ea = (av >> mw) & emax;    eb = (bv >> mw) & emax;
        fa = av & mmask;           fb = bv & mmask;
        s  = sa ^ sb;
        an = (ea == emax) && (fa != 0);  bn = (eb == emax) && (fb != 0);
        ai = (ea == emax) && (fa == 0);  bi = (eb == emax) && (fb == 0);
        az = (ea == 0);                  bz = (eb == 0);
        qnan = (emax << mw) | (longint'(1) << (mw - 1));
        if (an || bn || (ai && bz) || (az && bi)) begin
            ov = qnan; fv = 8;
        end else if (ai || bi) begin
            ov = (s << (w - 1)) | (emax << mw); fv = 0;
        end else if (az || bz) begin
            ov = s << (w - 1); fv = 0;
        end else begin
            ma  = fa | (longint'(1) << mw);
            mb  = fb | (longint'(1) << mw);
            val = ma * mb;
            e   = ea + eb - bias;
            if ((val >> (2 * mw + 1)) != 0) begin
                e++; sh = mw + 1;
            end else begin
                sh = mw;
            end
            q    = val >> sh;
            rem  = val - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && (q & 1) == 1)) q++;
            if ((q >> (mw + 1)) != 0) begin
                q = q >> 1; e++;
            end
            if (e >= emax) begin
                ov = (s << (w - 1)) | (emax << mw); fv = 5;
            end else if (e <= 0) begin
                ov = s << (w - 1); fv = 3;
            end else begin
                ov = (s << (w - 1)) | (e << mw) | (q & mmask);
                fv = (rem != 0) ? 1 : 0;
            end
        end
    endfunction

    function automatic logic [15:0] rand_op();
        logic [7:0] e;
        logic [6:0] f;
        logic       s;
        int sel;
        sel = $urandom_range(0, 9);
        s   = 1'($urandom);
        f   = 7'($urandom);
        case (sel)
            0:       e = 8'd0;
            1:       begin e = 8'd255; if ($urandom_range(0, 1) == 0) f = 7'd0; end
            2, 3:    e = 8'($urandom_range(1, 40));
            4, 5:    e = 8'($urandom_range(200, 254));
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {s, e, f};
    endfunction

    // Scoreboard: {tag, flags, o}
    logic [23:0] exp_q[$];
    logic        fire_in, fire_out, hold_pending;
    logic [23:0] held;
    int          delivered, stall_cnt;

    // One stream cycle: drive, check output/hold, record accepted operands, advance clock
    task automatic cyc(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                       input logic [3:0] it, input logic ordy);
        longint ov, fv;
        logic [23:0] e;
        if (hold_pending) begin
            chk("stall_hold_valid", 64'(out_valid), 64'd1);
            chk("stall_hold_data", 64'({out_tag, flags, o}), 64'(held));
            hold_pending = 1'b0;
        end
        in_valid = iv; a = ia; b = ib; in_tag = it; out_ready = ordy;
        #1;
        fire_in  = in_valid & in_ready;
        fire_out = out_valid & out_ready;
        if (fire_out) begin
            if (exp_q.size() == 0) begin
                chk("spurious_output", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("stream_o", 64'(o), 64'(e[15:0]));
                chk("stream_flags", 64'(flags), 64'(e[19:16]));
                chk("stream_tag", 64'(out_tag), 64'(e[23:20]));
                delivered++;
            end
        end
        if (out_valid && !out_ready) begin
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            hold_pending = 1'b1;
            held = {out_tag, flags, o};
            stall_cnt++;
        end
        if (fire_in) begin
            ref_mul(8, 7, longint'(ia), longint'(ib), ov, fv);
            exp_q.push_back({it, fv[3:0], ov[15:0]});
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            cyc(1'b0, 16'h0000, 16'h0000, 4'h0, 1'b1);
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        hold_pending = 1'b0;
    endtask

    // Directed single operation on the BF16 instance with latency measurement
    task automatic dir(input string name, input logic [15:0] ia, input logic [15:0] ib,
                       input logic [15:0] oe, input logic [3:0] fe);
        int lat;
        in_valid = 1'b1; a = ia; b = ib; in_tag = 4'hA; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_lat"}, 64'(lat), 64'd3);
        chk({name, "_o"}, 64'(o), 64'(oe));
        chk({name, "_flags"}, 64'(flags), 64'(fe));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int next, k;
        rst_n = 1'b0;
        in_valid = 1'b0; a = 16'h0000; b = 16'h0000; in_tag = 4'h0; out_ready = 1'b1;
        h_in_valid = 1'b0; h_a = 16'h0000; h_b = 16'h0000; h_in_tag = 4'h0; h_out_ready = 1'b1;
        hold_pending = 1'b0; delivered = 0; stall_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_o", 64'(o), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        dir("bf_basic1", 16'h3FC0, 16'h3FC0, 16'h4010, 4'b0000);
        dir("bf_basic2", 16'hBF80, 16'h4000, 16'hC000, 4'b0000);
        dir("rnd_down",  16'h3F81, 16'h3F81, 16'h3F82, 4'b0001);
        dir("rnd_tie",   16'h3F81, 16'h3FC0, 16'h3FC2, 4'b0001);
        dir("inf_x_zero",16'h7F80, 16'h0000, 16'h7FC0, 4'b1000);
        dir("nan_in",    16'h7FC1, 16'h3F80, 16'h7FC0, 4'b1000);
        dir("neg_inf",   16'hFF80, 16'h4000, 16'hFF80, 4'b0000);
        dir("neg_zero",  16'h8000, 16'h4000, 16'h8000, 4'b0000);
        dir("overflow",  16'h7F00, 16'h4000, 16'h7F80, 4'b0101);
        dir("underflow", 16'h0080, 16'h3F00, 16'h0000, 4'b0011);
        dir("subnormal", 16'h0001, 16'h3F80, 16'h0000, 4'b0000);

        // Backpressure: 16 tagged operands, output stalled for 5 cycles mid-stream
        next = 0; k = 0; delivered = 0; stall_cnt = 0;
        while (next < 16 && k < 100) begin
            cyc(1'b1, rand_op(), rand_op(), 4'(next), !(k >= 6 && k < 11));
            if (fire_in) next++;
            k++;
        end
        drain();
        chk("bp_accepted", 64'(next), 64'd16);
        chk("bp_delivered", 64'(delivered), 64'd16);
        chk("bp_stall_cycles", 64'(stall_cnt), 64'd5);

        // Reset with results in flight
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, rand_op(), rand_op(), 4'(i), 1'b1);
        end
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_o", 64'(o), 64'd0);
        exp_q.delete();
        hold_pending = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", 64'(out_valid), 64'd0);
        dir("post_rst", 16'h3FC0, 16'h3FC0, 16'h4010, 4'b0000);

        // Randomized stream with random input gaps and output stalls
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, rand_op(), rand_op(), 4'($urandom),
                $urandom_range(0, 3) != 0);
        end
        drain();

        // FP16 configuration
        begin
            int lat;
            h_in_valid = 1'b1; h_a = 16'h3E00; h_b = 16'h3E00; h_in_tag = 4'h5;
            @(posedge clk); #1;
            h_in_valid = 1'b0;
            lat = 0;
            while (!h_out_valid && lat < 10) begin
                @(posedge clk); #1;
                lat++;
            end
            chk("fp16_lat", 64'(lat), 64'd3);
            chk("fp16_o", 64'(h_o), 64'h4080);
            chk("fp16_flags", 64'(h_flags), 64'd0);
            chk("fp16_tag", 64'(h_out_tag), 64'h5);
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
